bubble_host_sequencer: RTL

//  Host-side controller for the bubble timing interface. Drives the active-low shift/replicate

---
 rtl/bubble_host_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/bubble_host_sequencer.sv
// Host-side sequencer for the bubble timing generator: seeks, reads serial
// bubble data on strobe falls, and packs it LSB-first onto a byte stream.
//
//   state | meaning
//   IDLE  | waiting for a command, output stream drains
//   SEEK  | /BS low, counting position_change edges down to zero
//   READ  | /BS and /REPEN low, sampling bits on strobe falling edges
//   STOP  | /BS and /REPEN released, waiting for the coil to stop
module bubble_host_sequencer #(
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 2048
) (
   input  logic                   master_clock,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_bootloop,
   input  logic [COUNT_WIDTH-1:0] cmd_seek,
   input  logic [COUNT_WIDTH-1:0] cmd_read,
   output logic                   bubble_shift_enable,
   output logic                   replicator_enable,
   output logic                   bootloop_enable,
   input  logic                   position_change,
   input  logic                   data_out_strobe,
   input  logic                   coil_enable,
   input  logic                   bubble_data,
   output logic [7:0]             data_byte,
   output logic                   data_last,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic                   overrun_err
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SEEK, READ, STOP} state_t;
   state_t state_q, state_d;

   logic [2:0]             pc_sync, strobe_sync;
   logic [1:0]             coil_sync, data_sync;
   logic [COUNT_WIDTH-1:0] seek_cnt, read_cnt;
   logic [WD_W-1:0]        wd_cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift_q, new_byte;
   logic                   skid_valid, skid_last;
   logic [7:0]             skid_byte;

   logic pc_rise, strobe_fall, coil_stopped, bit_s;
   logic accept, active, wd_expired, timeout_hit;
   logic seek_step, shift_en, byte_done, byte_last;
   logic pop, ovr_set;
   logic ov_d, ol_d, sv_d, sl_d;
   logic [7:0] ob_d, sb_d;

   // edges come from stage 2 vs stage 3; bubble_data/coil use stage 2 for equal delay
   assign pc_rise      = pc_sync[1] & ~pc_sync[2];
   assign strobe_fall  = ~strobe_sync[1] & strobe_sync[2];
   assign coil_stopped = coil_sync[1];
   assign bit_s        = data_sync[1];

   assign cmd_ready           = (state_q == IDLE) && !data_valid && !skid_valid;
   assign accept              = cmd_valid && cmd_ready;
   assign active              = (state_q == SEEK) || (state_q == READ);
   assign busy                = (state_q != IDLE);
   assign bubble_shift_enable = !active;
   assign replicator_enable   = (state_q != READ);
   assign wd_expired          = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_hit         = active && wd_expired && !pc_rise;
   assign new_byte            = shift_q | (8'(bit_s) << bit_idx);
   assign pop                 = data_valid && data_ready;

   // input synchronizers
   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_sync     <= '0;
         strobe_sync <= '0;
         coil_sync   <= '0;
         data_sync   <= '0;
      end else begin
         pc_sync     <= {pc_sync[1:0], position_change};
         strobe_sync <= {strobe_sync[1:0], data_out_strobe};
         coil_sync   <= {coil_sync[0], coil_enable};
         data_sync   <= {data_sync[0], bubble_data};
      end
   end

   // next-state and per-cycle step decisions
   always_comb begin
      state_d   = state_q;
      seek_step = 1'b0;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      byte_last = 1'b0;
      case (state_q)
         IDLE: if (accept)
            state_d = (cmd_seek != '0) ? SEEK : ((cmd_read != '0) ? READ : STOP);
         SEEK: begin
            if (timeout_hit) state_d = STOP;
            else if (pc_rise) begin
               seek_step = 1'b1;
               if (seek_cnt == COUNT_WIDTH'(1))
                  state_d = (read_cnt != '0) ? READ : STOP;
            end
         end
         READ: begin
            if (timeout_hit) state_d = STOP;
            else if (strobe_fall) begin
               shift_en  = 1'b1;
               byte_last = (read_cnt == COUNT_WIDTH'(1));
               byte_done = (bit_idx == 3'd7) || byte_last;
               if (byte_last) state_d = STOP;
            end
         end
         STOP: if (coil_stopped) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output register + skid: a same-cycle accept frees a slot before the new byte lands
   always_comb begin
      ov_d    = data_valid;
      ob_d    = data_byte;
      ol_d    = data_last;
      sv_d    = skid_valid;
      sb_d    = skid_byte;
      sl_d    = skid_last;
      ovr_set = 1'b0;
      if (pop) begin
         ov_d = skid_valid;
         ob_d = skid_byte;
         ol_d = skid_last;
         sv_d = 1'b0;
      end
      if (byte_done) begin
         if (!ov_d) begin
            ov_d = 1'b1;
            ob_d = new_byte;
            ol_d = byte_last;
         end else if (!sv_d) begin
            sv_d = 1'b1;
            sb_d = new_byte;
            sl_d = byte_last;
         end else begin
            ovr_set = 1'b1;
         end
      end
   end

   // state, counters, packer, stream registers and status flags
   always_ff @(posedge master_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         seek_cnt        <= '0;
         read_cnt        <= '0;
         wd_cnt          <= '0;
         bit_idx         <= '0;
         shift_q         <= '0;
         data_valid      <= 1'b0;
         data_byte       <= '0;
         data_last       <= 1'b0;
         skid_valid      <= 1'b0;
         skid_byte       <= '0;
         skid_last       <= 1'b0;
         bootloop_enable <= 1'b0;
         done            <= 1'b0;
         timeout_err     <= 1'b0;
         overrun_err     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_valid <= ov_d;
         data_byte  <= ob_d;
         data_last  <= ol_d;
         skid_valid <= sv_d;
         skid_byte  <= sb_d;
         skid_last  <= sl_d;
         done       <= (state_q == STOP) && coil_stopped;

         if (active && (state_d == state_q) && !pc_rise) wd_cnt <= wd_cnt + WD_W'(1);
         else                                            wd_cnt <= '0;

         if (accept) begin
            seek_cnt        <= cmd_seek;
            read_cnt        <= cmd_read;
            bit_idx         <= '0;
            shift_q         <= '0;
            bootloop_enable <= cmd_bootloop;
            timeout_err     <= 1'b0;
            overrun_err     <= 1'b0;
         end else begin
            if (seek_step && seek_cnt != '0) seek_cnt <= seek_cnt - COUNT_WIDTH'(1);
            if (shift_en) begin
               if (read_cnt != '0) read_cnt <= read_cnt - COUNT_WIDTH'(1);
               if (byte_done) begin
                  bit_idx <= '0;
                  shift_q <= '0;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  shift_q <= new_byte;
               end
            end
            if (timeout_hit) timeout_err <= 1'b1;
            if (ovr_set)     overrun_err <= 1'b1;
            if ((state_q == STOP) && (state_d == IDLE)) bootloop_enable <= 1'b0;
         end
      end
   end
endmodule
